// File: rtl/sipo_word_assembler.sv
// rtl/sipo_word_assembler.sv - LSB-first serial-to-word assembler feeding a first-word-fall-through FIFO.
module sipo_word_assembler #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     sin,
    input  logic                     sin_valid,
    input  logic                     sof,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

    // Assertion is immediate; release is retimed through two flops.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;

    assign word     = {sin, sr[WIDTH-1:1]};
    assign push_req = sin_valid && !sof && (bit_cnt == LAST_BIT);
    assign full     = (level == FULL_LVL);
    assign pop      = out_valid && out_ready;
    // A pop on the same edge frees the slot the new word needs.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (sin_valid) begin
            if (sof) begin
                sr      <= {sin, {(WIDTH-1){1'b0}}};
                bit_cnt <= CW'(1);
            end else begin
                sr      <= word;
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  overflow <= 1'b0;
        else if (push_req && !push)  overflow <= 1'b1;
        else if (ovf_clr)            overflow <= 1'b0;
    end

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sipo_word_assembler.sv
// tb/tb_sipo_word_assembler.sv - directed table and sequence checks for sipo_word_assembler.
module tb_sipo_word_assembler;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       sin, sin_valid, sof, out_ready, ovf_clr;
    logic [3:0] out_data;
    logic       out_valid;
    logic [2:0] level;
    logic [1:0] bit_cnt;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    sipo_word_assembler #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .areset_n(areset_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .bit_cnt(bit_cnt), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, b, s, r;
        logic [3:0] d;
        logic       ov;
        logic [2:0] lv;
        logic [1:0] cn;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic b, input logic s, input logic r, input logic c);
        sin_valid = v; sin = b; sof = s; out_ready = r; ovf_clr = c;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [3:0] w, input logic r_last, input logic c_last);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, w[i], 1'b0, (i == 3) ? r_last : 1'b0, (i == 3) ? c_last : 1'b0);
    endtask

    task automatic chk_all(input string name, input logic [3:0] d, input logic ov,
                           input logic [2:0] lv, input logic [1:0] cn, input logic of);
        chk(name, {out_data, out_valid, level, bit_cnt, overflow}, {d, ov, lv, cn, of});
    endtask

    initial begin
        logic [3:0] exp_q [4];
        logic [3:0] bits37;
        logic [3:0] word_a;

        // v b s r : data valid level cnt
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd2};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd3};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hD, 1'b1, 3'd1, 2'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd2};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 2'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd2};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 2'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd3};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 3'd1, 2'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 2'd0};

        areset_n = 1'b0;
        sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset_state", 4'h0, 1'b0, 3'd0, 2'd0, 1'b0);
        areset_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].r, 1'b0);
            chk($sformatf("table_row_%0d", i), {out_data, out_valid, level, bit_cnt, overflow},
                {tbl[i].d, tbl[i].ov, tbl[i].lv, tbl[i].cn, 1'b0});
        end

        // Bits 1,0,0,1 separated by idle gaps
        bits37 = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cyc(1, bits37[i], 0, 0, 0);
            chk($sformatf("gap_cnt_%0d", i), bit_cnt, (i + 1) % 4);
            if (i < 3) begin
                for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0);
                chk($sformatf("gap_hold_%0d", i), bit_cnt, i + 1);
            end
        end
        chk_all("gap_word", 4'h9, 1'b1, 3'd1, 2'd0, 1'b0);
        cyc(0, 0, 0, 1, 0);
        chk_all("gap_pop", 4'h0, 1'b0, 3'd0, 2'd0, 1'b0);

        // Overflow: fifth word dropped; clear on the same edge loses to set
        for (int w = 1; w <= 5; w++) send_word(4'(w), 1'b0, (w == 5));
        chk_all("ovf_full", 4'h1, 1'b1, 3'd4, 2'd0, 1'b1);
        for (int w = 1; w <= 4; w++) begin
            chk($sformatf("ovf_drain_%0d", w), out_data, w);
            cyc(0, 0, 0, 1, 0);
        end
        chk_all("ovf_empty", 4'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        cyc(0, 0, 0, 0, 1);
        chk("ovf_clear", overflow, 1'b0);

        // Push into full FIFO with simultaneous pop
        for (int w = 1; w <= 4; w++) send_word(4'(w), 1'b0, 1'b0);
        chk_all("full_no_ovf", 4'h1, 1'b1, 3'd4, 2'd0, 1'b0);
        word_a = 4'hA;
        for (int i = 0; i < 4; i++) cyc(1, word_a[i], 0, (i == 3), 0);
        chk_all("push_pop_full", 4'h2, 1'b1, 3'd4, 2'd0, 1'b0);
        exp_q = '{4'h2, 4'h3, 4'h4, 4'hA};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain_%0d", i), out_data, exp_q[i]);
            cyc(0, 0, 0, 1, 0);
        end
        chk("pp_empty", level, 3'd0);

        // Asynchronous reset mid-word
        send_word(4'h3, 1'b0, 1'b0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk_all("pre_reset", 4'h3, 1'b1, 3'd1, 2'd2, 1'b0);
        sin_valid = 1'b0;
        #2 areset_n = 1'b0;
        #1 chk_all("async_reset", 4'h0, 1'b0, 3'd0, 2'd0, 1'b0);
        @(negedge clk);
        areset_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("post_reset_cnt", bit_cnt, 2'd1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_all("post_reset_word", 4'h6, 1'b1, 3'd1, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
